// File: rtl/rv32_decode_stage_if.sv
// Handshake bundle for the RV32I decode stage: upstream fetch entry in, decoded entry out.
// The master drives instructions and sinks decoded entries; the decode stage is the slave.
interface rv32_decode_stage_if #(
  parameter int PC_W  = 32,
  parameter int IMM_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [PC_W-1:0]  in_pc;

  logic             out_valid;
  logic             out_ready;
  logic [6:0]       out_opcode;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [2:0]       out_funct3;
  logic [6:0]       out_funct7;
  logic [2:0]       out_fmt;
  logic [IMM_W-1:0] out_imm;
  logic             out_rs1_en;
  logic             out_rs2_en;
  logic             out_rd_we;
  logic             out_illegal;
  logic [PC_W-1:0]  out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_rs1, out_rs2, out_rd,
           out_funct3, out_funct7, out_fmt, out_imm, out_rs1_en, out_rs2_en,
           out_rd_we, out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_rs1, out_rs2, out_rd,
           out_funct3, out_funct7, out_fmt, out_imm, out_rs1_en, out_rs2_en,
           out_rd_we, out_illegal, out_pc
  );
endinterface

// File: rtl/rv32_decode_stage.sv
// Registered RV32I decode stage: full base-format decode with immediate assembly,
// illegal-encoding detection, a 2-entry skid buffer and a saturating illegal counter.
module rv32_decode_stage #(
  parameter int IMM_W        = 32,
  parameter int PC_W         = 32,
  parameter bit STRICT_CHECK = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  rv32_decode_stage_if.slave  bus,
  output logic [CNT_W-1:0]    illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    fmt_e             fmt;
    logic [IMM_W-1:0] imm;
    logic             rs1_en;
    logic             rs2_en;
    logic             rd_we;
    logic             illegal;
    logic [PC_W-1:0]  pc;
  } entry_t;

  entry_t            dec;
  entry_t            m_q, m_d, s_q, s_d;
  logic              m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       ins;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic              bad_funct;
  logic              bad_op;
  logic signed [31:0] imm32;
  logic              accept;
  logic              consume;

  assign ins = bus.in_instr;
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  always_comb begin
    dec        = '0;
    dec.opcode = ins[6:0];
    dec.rs1    = ins[19:15];
    dec.rs2    = ins[24:20];
    dec.rd     = ins[11:7];
    dec.funct3 = f3;
    dec.funct7 = f7;
    dec.pc     = bus.in_pc;
    dec.fmt    = FMT_NONE;
    bad_funct  = 1'b0;
    bad_op     = 1'b0;
    imm32      = '0;
    case (ins[6:0])
      7'b0110011: begin
        dec.fmt   = FMT_R;
        bad_funct = !(f7 == 7'b0000000 || f7 == 7'b0100000) ||
                    (f7 == 7'b0100000 && !(f3 == 3'b000 || f3 == 3'b101));
      end
      7'b0010011: begin
        dec.fmt   = FMT_I;
        bad_funct = (f3 == 3'b001 && f7 != 7'b0000000) ||
                    (f3 == 3'b101 && !(f7 == 7'b0000000 || f7 == 7'b0100000));
      end
      7'b0000011: begin
        dec.fmt   = FMT_I;
        bad_funct = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      end
      7'b1100111: begin
        dec.fmt   = FMT_I;
        bad_funct = (f3 != 3'b000);
      end
      7'b1110011, 7'b0001111: dec.fmt = FMT_I;
      7'b0100011: begin
        dec.fmt   = FMT_S;
        bad_funct = (f3 >= 3'b011);
      end
      7'b1100011: begin
        dec.fmt   = FMT_B;
        bad_funct = (f3 == 3'b010 || f3 == 3'b011);
      end
      7'b0110111, 7'b0010111: dec.fmt = FMT_U;
      7'b1101111:             dec.fmt = FMT_J;
      default:                bad_op  = 1'b1;
    endcase

    dec.illegal = bad_op || (ins[1:0] != 2'b11) || (STRICT_CHECK && bad_funct);

    case (dec.fmt)
      FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm32 = {ins[31:12], 12'b0};
      FMT_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase

    if (dec.illegal) begin
      dec.fmt = FMT_NONE;
    end else begin
      dec.imm    = IMM_W'(imm32);
      dec.rs1_en = dec.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
      dec.rs2_en = dec.fmt inside {FMT_R, FMT_S, FMT_B};
      dec.rd_we  = (dec.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (dec.rd != 5'd0);
    end
  end

  assign bus.in_ready = !s_valid_q;
  assign accept       = bus.in_valid && !s_valid_q;
  assign consume      = m_valid_q && bus.out_ready;

  // M refills from S first; new input only lands in S while M is stalled.
  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    cnt_d     = cnt_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || bus.out_ready) begin
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_d       = dec;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_d       = dec;
      s_valid_d = 1'b1;
    end
    if (consume && m_q.illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.out_valid   = m_valid_q;
  assign bus.out_opcode  = m_q.opcode;
  assign bus.out_rs1     = m_q.rs1;
  assign bus.out_rs2     = m_q.rs2;
  assign bus.out_rd      = m_q.rd;
  assign bus.out_funct3  = m_q.funct3;
  assign bus.out_funct7  = m_q.funct7;
  assign bus.out_fmt     = m_q.fmt;
  assign bus.out_imm     = m_q.imm;
  assign bus.out_rs1_en  = m_q.rs1_en;
  assign bus.out_rs2_en  = m_q.rs2_en;
  assign bus.out_rd_we   = m_q.rd_we;
  assign bus.out_illegal = m_q.illegal;
  assign bus.out_pc      = m_q.pc;
  assign illegal_cnt     = cnt_q;

endmodule

// File: doc/rv32_decode_stage.md
Name: rv32_decode_stage

Overview:
- Registered RV32I decode stage; successor to the combinational R/I-only decoder.
- Covers all base formats (R, I, S, B, U, J), assembles sign-extended immediates, and flags illegal encodings.
- Valid/ready handshake on both sides, with a 2-entry skid buffer for full throughput under backpressure.
- Sits between instruction fetch and register-read/execute.

Parameters:
- IMM_W, 32, width of sign-extended immediate output (legal values ≥32).
- PC_W, 32, width of PC carried alongside the instruction.
- STRICT_CHECK, 1, when 1 funct3/funct7 legality checks are enforced; when 0 only the opcode and instr[1:0] are checked.
- CNT_W, 16, width of saturating illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush; drops all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; equals !skid_valid.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction address.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  downstream accepts.
- out_opcode  out  7  instr[6:0].
- out_rs1 / out_rs2 / out_rd  out  5 each  instr[19:15] / [24:20] / [11:7].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_fmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- out_imm  out  IMM_W  sign-extended immediate.
- out_rs1_en / out_rs2_en  out  1 each  operand read required.
- out_rd_we  out  1  register write required.
- out_illegal  out  1  illegal encoding.
- out_pc  out  PC_W  PC of the entry.
- illegal_cnt  out  CNT_W  count of illegal entries delivered; saturates.

Behaviour:
- Reset, asynchronous on rst_n low:
  - Both buffer valids clear; all out_* fields read 0; illegal_cnt = 0.
  - in_ready = 1 throughout reset and after it.
  - Reset mid-transfer discards everything buffered.
- Decode is combinational on in_instr. The result is captured on the in_valid & in_ready edge.
- Latency: 1 cycle from input handshake to out_valid.
- Opcode classes:
  - 0110011 → R.
  - 0010011, 0000011, 1100111, 1110011, 0001111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Anything else, or instr[1:0] != 11 → illegal.
- Immediate construction, all sign-extended from instr[31] to IMM_W:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R: 0.
- Enable rules:
  - rs1_en: R, I, S, B.
  - rs2_en: R, S, B.
  - rd_we: R, I, U, J, but only when rd != 0.
- STRICT_CHECK = 1 illegal conditions:
  - R: funct7 not 0000000/0100000, or funct7 = 0100000 with funct3 not 000/101.
  - OP-IMM: funct3 = 001 with funct7 != 0; funct3 = 101 with funct7 not 0000000/0100000.
  - LOAD: funct3 ∈ {011, 110, 111}.
  - STORE: funct3 ≥ 011.
  - BRANCH: funct3 ∈ {010, 011}.
  - JALR: funct3 != 000.
- Illegal entry output:
  - fmt = 7, imm = 0, rs1_en = rs2_en = rd_we = 0, out_illegal = 1.
  - Raw fields (opcode, rs1, rs2, rd, funct3, funct7) and pc still presented.
- Skid buffer: main register M drives outputs; skid register S.
  - Accept when M is empty or out_ready is high → write M.
  - Accept while M is held (out_valid & !out_ready) → write S.
  - M consumed while S valid → M ← S and S clears, in the same edge.
  - Simultaneous consume and accept with S empty → M ← new entry.
  - Full (S valid) → in_ready = 0; no entry dropped or duplicated.
  - Output fields hold stable while out_valid & !out_ready.
- flush:
  - M and S valids clear next edge; an input accepted in the flush cycle is discarded.
  - illegal_cnt is unaffected.
- illegal_cnt:
  - Increments on out_valid & out_ready & out_illegal.
  - Holds at 2^CNT_W − 1 once reached; no wrap.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3) with out_ready = 1 → next cycle: out_valid = 1, rs1 = 1, rs2 = 2, rd = 3, fmt = 0, rd_we = 1, imm = 0, illegal = 0.
- Immediate forms:
  - ADDI x5,x0,-1 (0xFFF00293) → imm = 0xFFFFFFFF, fmt = 1.
  - SW x2,-4(x1) (0xFE20AE23) → imm = 0xFFFFFFFC, fmt = 2, rd_we = 0.
  - BEQ x0,x0,-8 (0xFE000CE3) → imm = 0xFFFFFFF8, fmt = 3.
  - LUI x1,0x12345 (0x123450B7) → imm = 0x12345000.
  - JAL x1,+2048 (0x001000EF) → imm = 0x00000800, fmt = 5.
- Illegal encodings:
  - 0x00000000 → illegal = 1, fmt = 7.
  - 0x4000F0B3 (funct7 = 0100000, funct3 = 111) → illegal with STRICT_CHECK = 1, legal with STRICT_CHECK = 0.
  - ADDI x0,x0,0 → legal, rd_we = 0.
- Backpressure, out_ready = 0 while streaming 3 entries → first in M, second in S, in_ready drops; third stalls. Raise out_ready → entries delivered in order, one per cycle, with no loss or duplication.
- flush asserted with M and S full → out_valid = 0 and in_ready = 1 next cycle. rst_n pulsed low mid-stream → outputs zero immediately.
- 65537 illegal entries delivered (CNT_W = 16) → illegal_cnt = 0xFFFF, no wrap.
